mem_bus_target: RTL and testbench

- Memory-side consumer of the shared processor memory bus: addr_data[9:0], read_write and write_commit, as driven by the pipeline control stage.
- Holds the 1024x12 unified instruction/data store. Serves asynchronous reads for fetch and load.
- Executes the two-phase store protocol: address phase, then data commit, including the upper-half STOREU variant. Latches the halt signalling.
- After reset, accepts a serial program preload before releasing the core.

---
 rtl/mem_bus_target_pkg.sv | 36 +++
 rtl/mem_bus_target_if.sv | 30 +++
 rtl/mem_bus_target_mem_array.sv | 24 ++
 rtl/mem_bus_target.sv | 101 ++++++++++
 tb/tb_mem_bus_target.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_target_pkg.sv
// Shared types and constants for the memory-side bus target: bus opcodes,
// target states and the STOREU half-select bit position.
package mem_bus_target_pkg;

  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 12;
  localparam int HALF_W         = DATA_W / 2;
  localparam int DEPTH          = 1 << ADDR_W;
  localparam int STOREU_SEL_BIT = 6;

  typedef enum logic [1:0] {
    BUS_READ,
    BUS_ST_ADDR,
    BUS_ST_COMMIT,
    BUS_HALT
  } bus_op_e;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    ST_PEND,
    HALTED
  } mem_state_e;

  function automatic bus_op_e decode_op(input logic read_write, input logic write_commit);
    bus_op_e op;
    case ({read_write, write_commit})
      2'b10:   op = BUS_READ;
      2'b00:   op = BUS_ST_ADDR;
      2'b01:   op = BUS_ST_COMMIT;
      default: op = BUS_HALT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_bus_target_if.sv
// Processor memory bus plus preload stream as seen by the memory target.
// Handshake: a preload word transfers on a cycle where prog_valid and prog_ready are both high.
interface mem_bus_target_if;
  import mem_bus_target_pkg::*;

  logic [ADDR_W-1:0] addr_data;
  logic              read_write;
  logic              write_commit;
  logic [DATA_W-1:0] mem_result;
  logic              mem_ready;
  logic              halted;
  logic              store_pending;
  logic              proto_err;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              prog_ready;
  mem_state_e        dbg_state;

  modport master (
    output addr_data, read_write, write_commit, prog_valid, prog_data, prog_last,
    input  mem_result, mem_ready, halted, store_pending, proto_err, prog_ready, dbg_state
  );

  modport slave (
    input  addr_data, read_write, write_commit, prog_valid, prog_data, prog_last,
    output mem_result, mem_ready, halted, store_pending, proto_err, prog_ready, dbg_state
  );

endinterface

// File: rtl/mem_bus_target_mem_array.sv
// Unified instruction/data store: asynchronous read, synchronous write with
// independent lower/upper half enables (both set for a full-word write).
module mem_bus_target_mem_array
  import mem_bus_target_pkg::*;
(
  input  logic              clk,
  input  logic              we_lo_i,
  input  logic              we_hi_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_lo_i) mem_q[waddr_i][HALF_W-1:0]      <= wdata_i[HALF_W-1:0];
    if (we_hi_i) mem_q[waddr_i][DATA_W-1:HALF_W] <= wdata_i[DATA_W-1:HALF_W];
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_bus_target.sv
// Memory bus target: serial preload after reset, then bus reads, two-phase
// (half-word) stores and sticky halt / protocol-error flags.
module mem_bus_target
  import mem_bus_target_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mem_bus_target_if.slave bus
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] st_addr_q, st_addr_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic              proto_err_q, proto_err_d;

  logic              we_lo, we_hi;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  bus_op_e           op;

  assign op = decode_op(bus.read_write, bus.write_commit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      st_addr_q   <= '0;
      load_ptr_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_addr_q   <= st_addr_d;
      load_ptr_q  <= load_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    st_addr_d   = st_addr_q;
    load_ptr_d  = load_ptr_q;
    proto_err_d = proto_err_q;
    we_lo       = 1'b0;
    we_hi       = 1'b0;
    waddr       = load_ptr_q;
    wdata       = bus.prog_data;

    case (state_q)
      LOAD: begin
        if (bus.prog_valid) begin
          we_lo      = 1'b1;
          we_hi      = 1'b1;
          load_ptr_d = load_ptr_q + 1'b1;
          if (bus.prog_last || load_ptr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
        end
      end
      RUN, ST_PEND: begin
        case (op)
          BUS_ST_ADDR: begin
            st_addr_d = bus.addr_data;
            state_d   = ST_PEND;
          end
          BUS_ST_COMMIT: begin
            if (state_q == ST_PEND) begin
              // Commit data is replicated; the half enables pick which half lands.
              waddr   = st_addr_q;
              wdata   = {bus.addr_data[HALF_W-1:0], bus.addr_data[HALF_W-1:0]};
              we_hi   = bus.addr_data[STOREU_SEL_BIT];
              we_lo   = !bus.addr_data[STOREU_SEL_BIT];
              state_d = RUN;
            end else begin
              proto_err_d = 1'b1;
            end
          end
          BUS_HALT: state_d = HALTED;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  mem_bus_target_mem_array u_mem_array (
    .clk     (clk),
    .we_lo_i (we_lo),
    .we_hi_i (we_hi),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (bus.addr_data),
    .rdata_o (rdata)
  );

  assign bus.mem_result    = (state_q == LOAD) ? '0 : rdata;
  assign bus.mem_ready     = (state_q != LOAD);
  assign bus.halted        = (state_q == HALTED);
  assign bus.store_pending = (state_q == ST_PEND);
  assign bus.proto_err     = proto_err_q;
  assign bus.prog_ready    = (state_q == LOAD);
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_mem_bus_target.sv
// Directed and randomized bench for mem_bus_target against a behavioural
// memory/flag model kept in plain arrays and booleans.
module tb_mem_bus_target;

  logic clk;
  logic rst_n;

  mem_bus_target_if bus_if ();

  mem_bus_target dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] mem_m [1024];
  bit          running_m, pend_m, halted_m, perr_m;
  int          pend_addr_m;
  int          ptr_m;
  logic [11:0] words_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_store_pending"}, bus_if.store_pending, pend_m);
    check({tag, "_halted"},        bus_if.halted,        halted_m);
    check({tag, "_proto_err"},     bus_if.proto_err,     perr_m);
    check({tag, "_mem_ready"},     bus_if.mem_ready,     running_m);
    check({tag, "_prog_ready"},    bus_if.prog_ready,    !running_m);
  endtask

  // One bus cycle: check combinational read data and flags, clock, then update the model.
  task automatic bus_op(input bit rw, input bit wc, input int addr);
    logic [5:0] d;
    bus_if.read_write   = rw;
    bus_if.write_commit = wc;
    bus_if.addr_data    = addr[9:0];
    #1;
    check("mem_result", bus_if.mem_result, running_m ? mem_m[addr] : 12'h000);
    check_status("pre");
    tick();
    if (running_m && !halted_m) begin
      if (!rw && !wc) begin
        pend_m      = 1;
        pend_addr_m = addr;
      end else if (!rw && wc) begin
        if (pend_m) begin
          d = addr[5:0];
          if (addr[6]) mem_m[pend_addr_m] = {d, mem_m[pend_addr_m][5:0]};
          else         mem_m[pend_addr_m] = {mem_m[pend_addr_m][11:6], d};
          pend_m = 0;
        end else begin
          perr_m = 1;
        end
      end else if (rw && wc) begin
        halted_m = 1;
        pend_m   = 0;
      end
    end
  endtask

  task automatic read_expect(input string tag, input int addr, input logic [11:0] exp);
    bus_if.read_write   = 1'b1;
    bus_if.write_commit = 1'b0;
    bus_if.addr_data    = addr[9:0];
    #1;
    check(tag, bus_if.mem_result, exp);
    bus_op(1'b1, 1'b0, addr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_mem_result",    bus_if.mem_result,    12'h000);
    check("rst_mem_ready",     bus_if.mem_ready,     1'b0);
    check("rst_halted",        bus_if.halted,        1'b0);
    check("rst_store_pending", bus_if.store_pending, 1'b0);
    check("rst_proto_err",     bus_if.proto_err,     1'b0);
    check("rst_prog_ready",    bus_if.prog_ready,    1'b1);
    tick();
    rst_n     = 1'b1;
    running_m = 0;
    pend_m    = 0;
    halted_m  = 0;
    perr_m    = 0;
    ptr_m     = 0;
    #1;
  endtask

  // Streams words_q into the array; junk on the bus must be ignored while loading.
  task automatic preload(input bit use_last, input bit gaps);
    int n;
    n = words_q.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus_if.prog_valid   = 1'b0;
        bus_if.read_write   = 1'($urandom_range(0, 1));
        bus_if.write_commit = 1'($urandom_range(0, 1));
        bus_if.addr_data    = 10'($urandom_range(0, 1023));
        #1;
        check("load_gap_result", bus_if.mem_result, 12'h000);
        check_status("load_gap");
        tick();
      end
      bus_if.prog_valid   = 1'b1;
      bus_if.prog_data    = words_q[i];
      bus_if.prog_last    = use_last && (i == n - 1);
      bus_if.read_write   = 1'($urandom_range(0, 1));
      bus_if.write_commit = 1'($urandom_range(0, 1));
      bus_if.addr_data    = 10'($urandom_range(0, 1023));
      #1;
      check("load_result", bus_if.mem_result, 12'h000);
      check_status("load");
      tick();
      mem_m[ptr_m] = words_q[i];
      ptr_m++;
    end
    bus_if.prog_valid = 1'b0;
    bus_if.prog_last  = 1'b0;
    running_m = 1;
    check("load_done_prog_ready", bus_if.prog_ready, 1'b0);
    check("load_done_mem_ready",  bus_if.mem_ready,  1'b1);
  endtask

  task automatic preload4();
    words_q = '{12'h0A5, 12'h123, 12'hFFF, 12'h800};
    preload(1'b1, 1'b0);
  endtask

  initial begin
    logic [11:0] v7;
    int          r;
    rst_n               = 1'b0;
    bus_if.addr_data    = '0;
    bus_if.read_write   = 1'b1;
    bus_if.write_commit = 1'b0;
    bus_if.prog_valid   = 1'b0;
    bus_if.prog_data    = '0;
    bus_if.prog_last    = 1'b0;
    #2;
    do_reset();

    // Full-depth preload without prog_last: must leave LOAD after the last address.
    words_q.delete();
    for (int i = 0; i < 1024; i++) words_q.push_back(12'($urandom_range(0, 4095)));
    preload(1'b0, 1'b1);
    check_status("full_load");

    // Random traffic on a small address window; stray prog_valid must be ignored.
    for (int i = 0; i < 400; i++) begin
      bus_if.prog_valid = 1'($urandom_range(0, 1));
      bus_if.prog_data  = 12'($urandom_range(0, 4095));
      r = $urandom_range(0, 2);
      case (r)
        0: bus_op(1'b1, 1'b0, $urandom_range(0, 1023));
        1: bus_op(1'b0, 1'b0, $urandom_range(0, 15));
        default: bus_op(1'b0, 1'b1, $urandom_range(0, 127));
      endcase
    end
    bus_if.prog_valid = 1'b0;
    check_status("rand_end");

    // Short preload with prog_last, then combinational read.
    do_reset();
    preload4();
    read_expect("read_addr2", 2, 12'hFFF);
    read_expect("read_addr0", 0, 12'h0A5);

    // Build 0xABC at address 5 from two half stores, then lower-half store.
    bus_op(1'b0, 1'b0, 5);
    bus_op(1'b0, 1'b1, 10'h03C);
    bus_op(1'b0, 1'b0, 5);
    bus_op(1'b0, 1'b1, 10'h06A);
    read_expect("build_abc", 5, 12'hABC);
    bus_op(1'b0, 1'b0, 5);
    check("pend_after_addr", bus_if.store_pending, 1'b1);
    bus_op(1'b0, 1'b1, 10'h015);
    check("pend_after_commit", bus_if.store_pending, 1'b0);
    read_expect("store_lower", 5, 12'hA95);

    // Upper-half store (STOREU).
    bus_op(1'b0, 1'b0, 5);
    bus_op(1'b0, 1'b1, 10'h03C);
    bus_op(1'b0, 1'b0, 5);
    bus_op(1'b0, 1'b1, 10'h06A);
    bus_op(1'b0, 1'b0, 5);
    bus_op(1'b0, 1'b1, 10'h055);
    read_expect("store_upper", 5, 12'h57C);

    // Repeated address phase: the later address wins.
    bus_op(1'b0, 1'b0, 1);
    bus_op(1'b0, 1'b0, 6);
    bus_op(1'b0, 1'b1, 10'h07F);
    read_expect("repeat_addr_old", 1, 12'h123);
    check("repeat_addr_new_hi", {26'd0, mem_m[6][11:6]}, 32'h3F);

    // Commit without address phase.
    bus_op(1'b0, 1'b1, 10'h03F);
    check("orphan_proto_err", bus_if.proto_err, 1'b1);
    read_expect("orphan_no_write5", 5, 12'h57C);
    bus_op(1'b0, 1'b0, 9);
    bus_op(1'b0, 1'b1, 10'h07F);
    check_status("after_err_store");
    check("proto_err_sticky", bus_if.proto_err, 1'b1);
    bus_op(1'b1, 1'b0, 9);

    // Reset mid-store discards the pending address.
    bus_op(1'b0, 1'b0, 7);
    check("mid_store_pend", bus_if.store_pending, 1'b1);
    v7 = mem_m[7];
    do_reset();
    check("rst_mid_store_ready", bus_if.mem_ready, 1'b0);
    preload4();
    bus_op(1'b0, 1'b1, 10'h03F);
    check("post_rst_proto_err", bus_if.proto_err, 1'b1);
    read_expect("post_rst_mem7", 7, v7);

    // Halt: terminal, stores ignored without proto_err, reads still served.
    do_reset();
    preload4();
    bus_op(1'b0, 1'b0, 4);
    bus_op(1'b1, 1'b1, 0);
    check("halt_flag", bus_if.halted, 1'b1);
    check("halt_drops_pend", bus_if.store_pending, 1'b0);
    bus_op(1'b0, 1'b0, 3);
    bus_op(1'b0, 1'b1, 10'h001);
    check("halt_no_pend", bus_if.store_pending, 1'b0);
    check("halt_no_perr", bus_if.proto_err, 1'b0);
    read_expect("halt_read3", 3, 12'h800);
    bus_op(1'b0, 1'b1, 10'h001);
    check_status("halt_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
